// File: rtl/key_scan_pkg.sv
// Shared types and helpers for the key_scan keypad scanner: FSM states,
// status-LED codes and the hex to seven-segment decode.
package key_scan_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    localparam logic [2:0] RGB_OVERRUN = 3'b100;
    localparam logic [2:0] RGB_HELD    = 3'b010;
    localparam logic [2:0] RGB_IDLE    = 3'b001;

    // Active-low {DP,g,f,e,d,c,b,a}; DP always off.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] i_hex);
        logic [7:0] v_seg;
        case (i_hex)
            4'h0:    v_seg = 8'hC0;
            4'h1:    v_seg = 8'hF9;
            4'h2:    v_seg = 8'hA4;
            4'h3:    v_seg = 8'hB0;
            4'h4:    v_seg = 8'h99;
            4'h5:    v_seg = 8'h92;
            4'h6:    v_seg = 8'h82;
            4'h7:    v_seg = 8'hF8;
            4'h8:    v_seg = 8'h80;
            4'h9:    v_seg = 8'h90;
            4'hA:    v_seg = 8'h88;
            4'hB:    v_seg = 8'h83;
            4'hC:    v_seg = 8'hC6;
            4'hD:    v_seg = 8'hA1;
            4'hE:    v_seg = 8'h86;
            default: v_seg = 8'h8E;
        endcase
        return v_seg;
    endfunction

endpackage

// File: rtl/key_scan_seg7_hex.sv
// Combinational 4-bit hex to active-low seven-segment cathode decoder.
module seg7_hex
    import key_scan_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [7:0] o_cathode_c
);

    assign o_cathode_c = hex_to_seg(i_hex);

endmodule

// File: rtl/key_scan.sv
// Row-scanned keypad matrix reader with press/release debounce, valid/ready key
// handoff, sticky overrun, status LED and hex display. Define KEY_SCAN_REPEAT_EN
// to re-accept a held key every 16*DEBOUNCE_CYCLES cycles.
module key_scan
    import key_scan_pkg::*;
#(
    parameter  int unsigned ROWS            = 4,
    parameter  int unsigned COLS            = 4,
    parameter  int unsigned SCAN_DIV        = 1000,
    parameter  int unsigned DEBOUNCE_CYCLES = 50000,
    localparam int unsigned CW              = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic            clk,
    input  logic            reset,
    output logic [ROWS-1:0] ROW_N,
    input  logic [COLS-1:0] COL_N,
    output logic [CW-1:0]   KEY,
    output logic            KEY_VALID,
    input  logic            KEY_READY,
    output logic            HELD,
    output logic            OVERRUN,
    output logic [2:0]      RGB,
    output logic [7:0]      cathode
);

    localparam int unsigned RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CLW  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned DIVW = $clog2(SCAN_DIV);
    localparam int unsigned CNTW = $clog2(DEBOUNCE_CYCLES + 1);

    state_t          r_state;
    logic [RW-1:0]   r_row;
    logic [CLW-1:0]  r_col;
    logic [DIVW-1:0] r_div;
    logic [CNTW-1:0] r_cnt;
    logic [ROWS-1:0] r_row_n;
    logic [CW-1:0]   r_key;
    logic            r_key_valid;
    logic            r_held;
    logic            r_overrun;
    logic [2:0]      r_rgb;
    logic [7:0]      r_cathode;

    logic            w_any_low;
    logic [CLW-1:0]  w_low_col;
    logic            w_col_n;
    logic [RW-1:0]   w_row_inc;
    logic            w_cnt_done;
    logic            w_press;
    logic            w_release;
    logic            w_repeat;
    logic            w_accept;
    logic            w_load;
    logic [CW-1:0]   w_code;
    logic [CW-1:0]   w_key_nxt;
    logic            w_valid_nxt;
    logic            w_held_nxt;
    logic            w_ovr_nxt;
    logic [2:0]      w_rgb_nxt;
    logic [7:0]      w_seg_c;

    function automatic logic [ROWS-1:0] row_drive(input logic [RW-1:0] i_row);
        return ~(ROWS'(1) << i_row);
    endfunction

    // Lowest-numbered active column wins when several are down.
    always_comb begin
        w_any_low = 1'b0;
        w_low_col = '0;
        for (int c = int'(COLS) - 1; c >= 0; c--) begin
            if (!COL_N[c]) begin
                w_any_low = 1'b1;
                w_low_col = CLW'(c);
            end
        end
    end

    assign w_col_n    = COL_N[r_col];
    assign w_row_inc  = (r_row == RW'(ROWS - 1)) ? '0 : r_row + RW'(1);
    assign w_cnt_done = (r_cnt == CNTW'(DEBOUNCE_CYCLES - 1));
    assign w_press    = (r_state == ST_DEBOUNCE) && !w_col_n && w_cnt_done;
    assign w_release  = (r_state == ST_RELEASE) && w_col_n && w_cnt_done;
    assign w_accept   = w_press || w_repeat;
    assign w_code     = CW'(32'(r_row) * COLS + 32'(r_col));

`ifdef KEY_SCAN_REPEAT_EN
    localparam int unsigned RPT  = 16 * DEBOUNCE_CYCLES;
    localparam int unsigned RPTW = $clog2(RPT + 1);

    logic [RPTW-1:0] r_rpt;
    logic            w_rpt_done;

    assign w_rpt_done = (r_rpt == RPTW'(RPT - 1));
    assign w_repeat   = (r_state == ST_HELD) && !w_col_n && w_rpt_done;

    // Repeat timer runs only while the key sits in HELD.
    always_ff @(posedge clk) begin
        if (reset || r_state != ST_HELD || w_rpt_done) begin
            r_rpt <= '0;
        end else begin
            r_rpt <= r_rpt + RPTW'(1);
        end
    end
`else
    assign w_repeat = 1'b0;
`endif

    // Handoff: an acceptance loads KEY unless a key is pending and not being taken.
    always_comb begin
        w_load      = w_accept && (!r_key_valid || KEY_READY);
        w_key_nxt   = w_load ? w_code : r_key;
        w_valid_nxt = w_load || (r_key_valid && !KEY_READY);
        w_ovr_nxt   = r_overrun || (w_accept && r_key_valid && !KEY_READY);
        w_held_nxt  = (r_held || w_press) && !w_release;
        w_rgb_nxt   = RGB_IDLE;
        if (w_ovr_nxt) begin
            w_rgb_nxt = RGB_OVERRUN;
        end else if (w_held_nxt) begin
            w_rgb_nxt = RGB_HELD;
        end
    end

    seg7_hex u_seg7_hex (
        .i_hex       (4'(w_key_nxt)),
        .o_cathode_c (w_seg_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_SCAN;
            r_row   <= '0;
            r_col   <= '0;
            r_div   <= '0;
            r_cnt   <= '0;
            r_row_n <= row_drive('0);
        end else begin
            case (r_state)
                ST_SCAN: begin
                    if (r_div == DIVW'(SCAN_DIV - 1)) begin
                        r_div <= '0;
                        if (w_any_low) begin
                            r_col   <= w_low_col;
                            r_cnt   <= '0;
                            r_state <= ST_DEBOUNCE;
                        end else begin
                            r_row   <= w_row_inc;
                            r_row_n <= row_drive(w_row_inc);
                        end
                    end else begin
                        r_div <= r_div + DIVW'(1);
                    end
                end
                ST_DEBOUNCE: begin
                    if (w_col_n) begin
                        r_state <= ST_SCAN;
                        r_row   <= w_row_inc;
                        r_row_n <= row_drive(w_row_inc);
                    end else if (w_cnt_done) begin
                        r_state <= ST_HELD;
                    end else begin
                        r_cnt <= r_cnt + CNTW'(1);
                    end
                end
                ST_HELD: begin
                    if (w_col_n) begin
                        r_cnt   <= '0;
                        r_state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!w_col_n) begin
                        r_state <= ST_HELD;
                    end else if (w_cnt_done) begin
                        r_state <= ST_SCAN;
                        r_row   <= w_row_inc;
                        r_row_n <= row_drive(w_row_inc);
                    end else begin
                        r_cnt <= r_cnt + CNTW'(1);
                    end
                end
                default: begin
                    r_state <= ST_SCAN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_key       <= '0;
            r_key_valid <= 1'b0;
            r_held      <= 1'b0;
            r_overrun   <= 1'b0;
            r_rgb       <= RGB_IDLE;
            r_cathode   <= 8'hC0;
        end else begin
            r_key       <= w_key_nxt;
            r_key_valid <= w_valid_nxt;
            r_held      <= w_held_nxt;
            r_overrun   <= w_ovr_nxt;
            r_rgb       <= w_rgb_nxt;
            r_cathode   <= w_seg_c;
        end
    end

    assign ROW_N     = r_row_n;
    assign KEY       = r_key;
    assign KEY_VALID = r_key_valid;
    assign HELD      = r_held;
    assign OVERRUN   = r_overrun;
    assign RGB       = r_rgb;
    assign cathode   = r_cathode;

endmodule

// File: tb/tb_key_scan.sv
// Directed self-checking bench for key_scan with a simulated 4x4 keypad matrix.
module tb_key_scan;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  ROW_N;
    logic [3:0]  COL_N;
    logic [3:0]  KEY;
    logic        KEY_VALID;
    logic        KEY_READY = 1'b0;
    logic        HELD;
    logic        OVERRUN;
    logic [2:0]  RGB;
    logic [7:0]  cathode;
    logic [15:0] pressed = '0;

    int vectors = 0;
    int miscompares = 0;

    int          n_xfer = 0;
    logic [3:0]  last_xfer_key = '0;
    int          n_valid_hi = 0;
    int          n_held = 0;
    int          n_rgb_bad = 0;

    key_scan #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk(clk), .reset(reset), .ROW_N(ROW_N), .COL_N(COL_N), .KEY(KEY),
        .KEY_VALID(KEY_VALID), .KEY_READY(KEY_READY), .HELD(HELD),
        .OVERRUN(OVERRUN), .RGB(RGB), .cathode(cathode)
    );

    always #5 clk = ~clk;

    // Keypad: a pressed switch pulls its column low while its row is driven.
    always_comb begin
        COL_N = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!ROW_N[r] && pressed[r*4+c]) COL_N[c] = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (KEY_VALID && KEY_READY) begin
            n_xfer        <= n_xfer + 1;
            last_xfer_key <= KEY;
        end
    end

    always @(negedge clk) begin
        if (KEY_VALID) n_valid_hi <= n_valid_hi + 1;
        if (HELD) begin
            n_held <= n_held + 1;
            if (RGB !== 3'b010) n_rgb_bad <= n_rgb_bad + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_held(input logic lvl, input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (HELD === lvl) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_valid(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (KEY_VALID === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    // Wait for a fresh arrival of row pattern pat (leave it first if already there).
    task automatic wait_row_fresh(input logic [3:0] pat, input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            if (ROW_N !== pat) break;
            @(negedge clk);
        end
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (ROW_N === pat) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pressed = '0;
        KEY_READY = 1'b0;
        tick(3);
        vectors++; if (ROW_N !== 4'b1110) begin miscompares++; $display("FAIL reset_row_n: got %b want 1110", ROW_N); end
        vectors++; if (KEY !== 4'd0) begin miscompares++; $display("FAIL reset_key: got %0d want 0", KEY); end
        vectors++; if (KEY_VALID !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", KEY_VALID); end
        vectors++; if (HELD !== 1'b0) begin miscompares++; $display("FAIL reset_held: got %b want 0", HELD); end
        vectors++; if (OVERRUN !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b want 0", OVERRUN); end
        vectors++; if (RGB !== 3'b001) begin miscompares++; $display("FAIL reset_rgb: got %b want 001", RGB); end
        vectors++; if (cathode !== 8'hC0) begin miscompares++; $display("FAIL reset_cathode: got %h want c0", cathode); end
        reset = 1'b0;
        tick(3);
        vectors++; if (ROW_N !== 4'b1110) begin miscompares++; $display("FAIL scan_row0_hold: got %b want 1110", ROW_N); end
        tick(1);
        vectors++; if (ROW_N !== 4'b1101) begin miscompares++; $display("FAIL scan_row1_step: got %b want 1101", ROW_N); end
    endtask

    task automatic test_single_press();
        int x0, h0, b0;
        bit ok;
        KEY_READY = 1'b1;
        x0 = n_xfer; h0 = n_held; b0 = n_rgb_bad;
        pressed[9] = 1'b1;
        tick(40);
        vectors++; if (HELD !== 1'b1) begin miscompares++; $display("FAIL press9_held: got %b want 1", HELD); end
        pressed = '0;
        wait_held(1'b0, 40, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL press9_release_timeout: got HELD=%b want 0", HELD); end
        vectors++; if (n_xfer - x0 !== 1) begin miscompares++; $display("FAIL press9_pulses: got %0d want 1", n_xfer - x0); end
        vectors++; if (last_xfer_key !== 4'd9) begin miscompares++; $display("FAIL press9_xfer_key: got %0d want 9", last_xfer_key); end
        vectors++; if (KEY !== 4'd9) begin miscompares++; $display("FAIL press9_key: got %0d want 9", KEY); end
        vectors++; if (cathode !== 8'h90) begin miscompares++; $display("FAIL press9_cathode: got %h want 90", cathode); end
        vectors++; if (n_held - h0 <= 0 || n_rgb_bad - b0 !== 0) begin miscompares++; $display("FAIL press9_rgb_held: held_cycles %0d bad_rgb %0d want >0 and 0", n_held - h0, n_rgb_bad - b0); end
        vectors++; if (RGB !== 3'b001) begin miscompares++; $display("FAIL press9_rgb_idle: got %b want 001", RGB); end
    endtask

    task automatic test_glitch();
        int x0, h0;
        bit ok;
        KEY_READY = 1'b1;
        x0 = n_xfer; h0 = n_held;
        wait_row_fresh(4'b1101, 40, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL glitch_row1_timeout: got %b want 1101", ROW_N); end
        pressed[7] = 1'b1;
        tick(5);
        pressed = '0;
        for (int i = 0; i < 20; i++) begin
            if (ROW_N !== 4'b1101) break;
            @(negedge clk);
        end
        vectors++; if (ROW_N !== 4'b1011) begin miscompares++; $display("FAIL glitch_resume_row2: got %b want 1011", ROW_N); end
        tick(10);
        vectors++; if (n_xfer - x0 !== 0 || KEY_VALID !== 1'b0) begin miscompares++; $display("FAIL glitch_no_key: got xfers %0d valid %b want 0 0", n_xfer - x0, KEY_VALID); end
        vectors++; if (n_held - h0 !== 0) begin miscompares++; $display("FAIL glitch_no_hold: got %0d held cycles want 0", n_held - h0); end
    endtask

    task automatic test_two_columns();
        int x0;
        bit ok;
        KEY_READY = 1'b1;
        x0 = n_xfer;
        pressed[0] = 1'b1;
        pressed[2] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (n_xfer != x0) begin ok = 1'b1; break; end
        end
        vectors++; if (!ok) begin miscompares++; $display("FAIL twocol_timeout: got no transfer want 1"); end
        vectors++; if (last_xfer_key !== 4'd0 || KEY !== 4'd0) begin miscompares++; $display("FAIL twocol_key: got %0d/%0d want 0", last_xfer_key, KEY); end
        vectors++; if (cathode !== 8'hC0) begin miscompares++; $display("FAIL twocol_cathode: got %h want c0", cathode); end
        pressed = '0;
        wait_held(1'b0, 40, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL twocol_release_timeout: got HELD=%b want 0", HELD); end
    endtask

    task automatic test_overrun();
        bit ok;
        KEY_READY = 1'b0;
        pressed[5] = 1'b1;
        wait_valid(60, ok);
        vectors++; if (!ok || KEY !== 4'd5) begin miscompares++; $display("FAIL ovr_first_key: got valid=%b key=%0d want 1 5", KEY_VALID, KEY); end
        pressed = '0;
        wait_held(1'b0, 40, ok);
        pressed[6] = 1'b1;
        wait_held(1'b1, 60, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL ovr_second_timeout: got HELD=%b want 1", HELD); end
        vectors++; if (KEY !== 4'd5 || KEY_VALID !== 1'b1) begin miscompares++; $display("FAIL ovr_key_kept: got key=%0d valid=%b want 5 1", KEY, KEY_VALID); end
        vectors++; if (OVERRUN !== 1'b1) begin miscompares++; $display("FAIL ovr_flag: got %b want 1", OVERRUN); end
        vectors++; if (RGB !== 3'b100) begin miscompares++; $display("FAIL ovr_rgb: got %b want 100", RGB); end
        pressed = '0;
        wait_held(1'b0, 40, ok);
        KEY_READY = 1'b1;
        tick(2);
        vectors++; if (KEY_VALID !== 1'b0 || last_xfer_key !== 4'd5) begin miscompares++; $display("FAIL ovr_drain: got valid=%b key=%0d want 0 5", KEY_VALID, last_xfer_key); end
        vectors++; if (OVERRUN !== 1'b1 || RGB !== 3'b100) begin miscompares++; $display("FAIL ovr_sticky: got %b rgb %b want 1 100", OVERRUN, RGB); end
    endtask

    task automatic test_reset_in_debounce();
        int x0, v0;
        bit ok;
        KEY_READY = 1'b1;
        pressed[14] = 1'b1;
        wait_row_fresh(4'b0111, 40, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL rstdb_row3_timeout: got %b want 0111", ROW_N); end
        tick(6);
        vectors++; if (ROW_N !== 4'b0111 || HELD !== 1'b0) begin miscompares++; $display("FAIL rstdb_in_debounce: got row %b held %b want 0111 0", ROW_N, HELD); end
        reset = 1'b1;
        pressed = '0;
        tick(1);
        vectors++; if (ROW_N !== 4'b1110) begin miscompares++; $display("FAIL rstdb_row_n: got %b want 1110", ROW_N); end
        vectors++; if (KEY !== 4'd0 || cathode !== 8'hC0) begin miscompares++; $display("FAIL rstdb_key: got %0d %h want 0 c0", KEY, cathode); end
        vectors++; if (KEY_VALID !== 1'b0 || HELD !== 1'b0) begin miscompares++; $display("FAIL rstdb_flags: got valid %b held %b want 0 0", KEY_VALID, HELD); end
        vectors++; if (OVERRUN !== 1'b0 || RGB !== 3'b001) begin miscompares++; $display("FAIL rstdb_status: got ovr %b rgb %b want 0 001", OVERRUN, RGB); end
        reset = 1'b0;
        x0 = n_xfer; v0 = n_valid_hi;
        tick(40);
        vectors++; if (n_xfer - x0 !== 0 || n_valid_hi - v0 !== 0) begin miscompares++; $display("FAIL rstdb_no_key: got xfers %0d valid cycles %0d want 0 0", n_xfer - x0, n_valid_hi - v0); end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_glitch();
        test_two_columns();
        test_overrun();
        test_reset_in_debounce();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
